// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline types and constants for the 5-stage core.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int              c_REG_W = 5;
    localparam logic [c_REG_W-1:0] c_X0 = '0;

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard compare between EX and ID.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipe_pkg::*;
(
    input  logic               i_idex_memread,
    input  logic [c_REG_W-1:0] i_idex_rd,
    input  logic [c_REG_W-1:0] i_ifid_rs1,
    input  logic [c_REG_W-1:0] i_ifid_rs2,
    output logic               o_hazard
);

    logic w_rs_match;

    assign w_rs_match = (i_idex_rd == i_ifid_rs1) || (i_idex_rd == i_ifid_rs2);
    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign o_hazard   = i_idex_memread && (i_idex_rd != c_X0) && w_rs_match;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush sequencer: memory-wait FSM, load-use bubble,
//               branch flush, saturating stall counter and timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               IDEX_MemRead_i,
    input  logic [c_REG_W-1:0] IDEX_Rd_i,
    input  logic [c_REG_W-1:0] IFID_Rs1_i,
    input  logic [c_REG_W-1:0] IFID_Rs2_i,
    input  logic               Branch_taken_i,
    input  logic               EXMEM_MemRead_i,
    input  logic               EXMEM_MemWrite_i,
    input  logic               mem_ack_i,
    output logic               mem_req_o,
    output logic               Stall_o,
    output logic               PCWrite_o,
    output logic               IFIDWrite_o,
    output logic               NoOp_o,
    output logic               Flush_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic               err_o
);

    localparam int                 c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = c_WAIT_W'(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [c_WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                r_err;

    logic w_mem_pending;
    logic w_mem_stall;
    logic w_load_use;

    load_use_detect u_load_use_detect (
        .i_idex_memread (IDEX_MemRead_i),
        .i_idex_rd      (IDEX_Rd_i),
        .i_ifid_rs1     (IFID_Rs1_i),
        .i_ifid_rs2     (IFID_Rs2_i),
        .o_hazard       (w_load_use)
    );

    assign w_mem_pending = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    // Gated by reset so an asserted reset withdraws the request at once,
    // even while the EX/MEM access is still presented.
    assign w_mem_stall   = rst_i && ((r_state == ST_REQ) ||
                                     ((r_state == ST_IDLE) && w_mem_pending));

    always_comb begin
        mem_req_o   = 1'b0;
        Stall_o     = 1'b0;
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
        NoOp_o      = 1'b0;
        Flush_o     = 1'b0;
        if (w_mem_stall) begin
            mem_req_o   = 1'b1;
            Stall_o     = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
        end else if (w_load_use) begin
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            NoOp_o      = 1'b1;
        end else if (Branch_taken_i) begin
            Flush_o     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if ((Stall_o || NoOp_o) && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_pending) begin
                        r_state <= ST_REQ;
                        r_wait  <= '0;
                    end
                end
                ST_REQ: begin
                    if (r_wait != c_WAIT_MAX) begin
                        r_wait <= r_wait + 1'b1;
                    end
                    if (r_wait == c_WAIT_LAST) begin
                        r_err <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed bench with a cycle-level reference model for
//               pipe_hazard_ctrl (CNT_W=4, TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_CNT_W = 4;
    localparam int c_TMO   = 4;
    localparam int c_SAT   = (1 << c_CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_Rd_i;
    logic [4:0]       IFID_Rs1_i;
    logic [4:0]       IFID_Rs2_i;
    logic             Branch_taken_i;
    logic             EXMEM_MemRead_i;
    logic             EXMEM_MemWrite_i;
    logic             mem_ack_i;
    logic             mem_req_o;
    logic             Stall_o;
    logic             PCWrite_o;
    logic             IFIDWrite_o;
    logic             NoOp_o;
    logic             Flush_o;
    logic [c_CNT_W-1:0] stall_cnt_o;
    logic             err_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_busy    = 1'b0;
    bit m_retire  = 1'b0;
    bit m_err     = 1'b0;
    int m_req_cyc = 0;
    int m_stalls  = 0;

    pipe_hazard_ctrl #(.CNT_W(c_CNT_W), .TIMEOUT(c_TMO)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .IDEX_MemRead_i   (IDEX_MemRead_i),
        .IDEX_Rd_i        (IDEX_Rd_i),
        .IFID_Rs1_i       (IFID_Rs1_i),
        .IFID_Rs2_i       (IFID_Rs2_i),
        .Branch_taken_i   (Branch_taken_i),
        .EXMEM_MemRead_i  (EXMEM_MemRead_i),
        .EXMEM_MemWrite_i (EXMEM_MemWrite_i),
        .mem_ack_i        (mem_ack_i),
        .mem_req_o        (mem_req_o),
        .Stall_o          (Stall_o),
        .PCWrite_o        (PCWrite_o),
        .IFIDWrite_o      (IFIDWrite_o),
        .NoOp_o           (NoOp_o),
        .Flush_o          (Flush_o),
        .stall_cnt_o      (stall_cnt_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // {mem_req, stall, pcwrite, ifidwrite, noop, flush}
    function automatic logic [5:0] exp_ctrl();
        logic mem;
        logic haz;
        mem = rst_i && (m_busy || (!m_retire && (EXMEM_MemRead_i || EXMEM_MemWrite_i)));
        haz = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
              ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));
        if (mem)            return 6'b110000;
        if (haz)            return 6'b000010;
        if (Branch_taken_i) return 6'b001101;
        return 6'b001100;
    endfunction

    function automatic bit exp_bubble();
        logic [5:0] e;
        e = exp_ctrl();
        return e[4] | e[1];
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_busy    <= 1'b0;
            m_retire  <= 1'b0;
            m_err     <= 1'b0;
            m_req_cyc <= 0;
            m_stalls  <= 0;
        end else begin
            if (exp_bubble() && m_stalls < c_SAT) m_stalls <= m_stalls + 1;
            if (m_retire) begin
                m_retire <= 1'b0;
            end else if (m_busy) begin
                m_req_cyc <= m_req_cyc + 1;
                if (m_req_cyc + 1 >= c_TMO) m_err <= 1'b1;
                if (mem_ack_i) begin
                    m_busy   <= 1'b0;
                    m_retire <= 1'b1;
                end
            end else if (EXMEM_MemRead_i || EXMEM_MemWrite_i) begin
                m_busy    <= 1'b1;
                m_req_cyc <= 0;
            end
        end
    end

    always @(negedge clk_i) begin : cmp
        logic [5:0] e;
        e = exp_ctrl();
        chk("mem_req_o",   int'(mem_req_o),   int'(e[5]));
        chk("Stall_o",     int'(Stall_o),     int'(e[4]));
        chk("PCWrite_o",   int'(PCWrite_o),   int'(e[3]));
        chk("IFIDWrite_o", int'(IFIDWrite_o), int'(e[2]));
        chk("NoOp_o",      int'(NoOp_o),      int'(e[1]));
        chk("Flush_o",     int'(Flush_o),     int'(e[0]));
        chk("stall_cnt_o", int'(stall_cnt_o), m_stalls);
        chk("err_o",       int'(err_o),       int'(m_err));
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic br, input logic exr,
                         input logic exw, input logic ack);
        IDEX_MemRead_i   = mr;
        IDEX_Rd_i        = rd;
        IFID_Rs1_i       = rs1;
        IFID_Rs2_i       = rs2;
        Branch_taken_i   = br;
        EXMEM_MemRead_i  = exr;
        EXMEM_MemWrite_i = exw;
        mem_ack_i        = ack;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        chk("rst_pcwrite", int'(PCWrite_o), 1);
        chk("rst_ifidwrite", int'(IFIDWrite_o), 1);
        chk("rst_stall", int'(Stall_o), 0);
        chk("rst_memreq", int'(mem_req_o), 0);
        chk("rst_noop_flush", int'({NoOp_o, Flush_o}), 0);
        chk("rst_cnt", int'(stall_cnt_o), 0);
        chk("rst_err", int'(err_o), 0);

        // Load access, ack on the 3rd REQ cycle, then a back-to-back access
        tick(); drive(0, 0, 0, 0, 0, 1, 0, 0); #1;
        chk("idle_stall", int'(Stall_o), 1);
        chk("idle_memreq", int'(mem_req_o), 1);
        chk("idle_pcwrite", int'(PCWrite_o), 0);
        tick();
        tick();
        tick(); drive(0, 0, 0, 0, 0, 1, 0, 1); #1;
        chk("req3_stall", int'(Stall_o), 1);
        tick(); drive(0, 0, 0, 0, 0, 1, 0, 0); #1;
        chk("done_stall", int'(Stall_o), 0);
        chk("done_memreq", int'(mem_req_o), 0);
        chk("done_pcwrite", int'(PCWrite_o), 1);
        chk("done_cnt", int'(stall_cnt_o), 4);
        tick(); #1;
        chk("b2b_memreq", int'(mem_req_o), 1);
        tick(); drive(0, 0, 0, 0, 0, 1, 0, 1);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("b2b_done_stall", int'(Stall_o), 0);
        chk("b2b_cnt", int'(stall_cnt_o), 6);
        tick(); #1;
        chk("quiet_memreq", int'(mem_req_o), 0);

        // Load-use bubble on rs2, then clears
        tick(); drive(1, 5, 1, 5, 0, 0, 0, 0); #1;
        chk("lu_noop", int'(NoOp_o), 1);
        chk("lu_pcwrite", int'(PCWrite_o), 0);
        chk("lu_ifidwrite", int'(IFIDWrite_o), 0);
        tick(); drive(0, 5, 1, 5, 0, 0, 0, 0); #1;
        chk("lu_clear_noop", int'(NoOp_o), 0);
        chk("lu_clear_pcwrite", int'(PCWrite_o), 1);
        chk("lu_cnt", int'(stall_cnt_o), 7);
        tick(); drive(1, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("x0_noop", int'(NoOp_o), 0);
        chk("x0_pcwrite", int'(PCWrite_o), 1);

        // Load-use masks a taken branch; branch flushes next cycle
        tick(); drive(1, 5, 5, 2, 1, 0, 0, 0); #1;
        chk("lubr_noop", int'(NoOp_o), 1);
        chk("lubr_flush", int'(Flush_o), 0);
        tick(); drive(0, 5, 5, 2, 1, 0, 0, 0); #1;
        chk("br_flush", int'(Flush_o), 1);
        chk("br_noop", int'(NoOp_o), 0);
        chk("br_pcwrite", int'(PCWrite_o), 1);
        chk("br_cnt", int'(stall_cnt_o), 8);

        // Store with no ack: timeout and counter saturation
        tick(); drive(0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("to_idle_stall", int'(Stall_o), 1);
        for (int i = 0; i < c_TMO; i++) tick();
        #1;
        chk("to_err_before", int'(err_o), 0);
        tick(); #1;
        chk("to_err_set", int'(err_o), 1);
        chk("to_cnt", int'(stall_cnt_o), 13);
        tick();
        tick();
        tick(); #1;
        chk("sat_cnt", int'(stall_cnt_o), 15);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("late_ack_stall", int'(Stall_o), 0);
        chk("late_ack_err", int'(err_o), 1);
        tick(); #1;
        chk("err_sticky", int'(err_o), 1);
        chk("sat_hold", int'(stall_cnt_o), 15);

        // Asynchronous reset in the middle of REQ
        tick(); drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick(); #1;
        chk("mid_req_memreq", int'(mem_req_o), 1);
        rst_i = 1'b0;
        #1;
        chk("arst_memreq", int'(mem_req_o), 0);
        chk("arst_stall", int'(Stall_o), 0);
        chk("arst_cnt", int'(stall_cnt_o), 0);
        chk("arst_err", int'(err_o), 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        #1;
        chk("rel_pcwrite", int'(PCWrite_o), 1);
        chk("rel_memreq", int'(mem_req_o), 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
